// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and key-index helpers for the 3x4 keypad scanner.
package kbd_pkg;

  localparam int NCOL  = 3;
  localparam int NROW  = 4;
  localparam int NKEY  = 10;
  localparam int KEY_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  // Index is col*4 + row; this relies on NROW being exactly 4.
  function automatic logic [KEY_W-1:0] key_index(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

  function automatic logic [KEY_W-1:0] lowest_set(input logic [NKEY-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = {KEY_W{1'b0}};
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key frame-rate debouncer: stable level flips after DEBOUNCE_CNT consecutive differing frames.
module key_debounce
  import kbd_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic eval_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q;

  // Next-state for the disagreement counter and the stable level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (eval_i) begin
      if (raw_i != stable_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
          stable_d = raw_i;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = {CNT_W{1'b0}};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign rise_o = stable_d & ~stable_q;

  // State registers; the press pulse lands in the same cycle the level rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= {CNT_W{1'b0}};
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= rise_o;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 3x4 keypad front end producing debounced levels and press pulses for keys 0..9.
module keypad_scanner
  import kbd_pkg::*;
#(
  parameter int SCAN_DIV     = 131072,
  parameter int SETTLE       = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NROW-1:0]   row_n,
  output logic [NCOL-1:0]   col_n,
  output logic [NKEY-1:0]   key_level,
  output logic [NKEY-1:0]   key_press,
  output logic [KEY_W-1:0]  key_code,
  output logic              key_valid,
  output logic              frame_done
);

  localparam int TICK_W = $clog2(SCAN_DIV);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        col_q, col_d;
  logic [NKEY-1:0]   raw_q, raw_d;
  logic [NCOL-1:0]   col_n_q, col_n_d;
  logic              frame_done_q, frame_d;
  logic [KEY_W-1:0]  key_code_q;
  logic              key_valid_q;
  logic [NKEY-1:0]   rise_s;

  // Scan sequencer: column dwell, row sampling and frame completion.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    col_d   = col_q;
    raw_d   = raw_q;
    frame_d = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = {TICK_W{1'b0}};
        col_d  = 2'd0;
        if (en) state_d = DRIVE;
        else    state_d = IDLE;
      end
      DRIVE: begin
        if (!en) begin
          state_d = IDLE;
          tick_d  = {TICK_W{1'b0}};
          col_d   = 2'd0;
        end else begin
          if (tick_q == TICK_W'(SETTLE)) begin
            // Indices 10 and 11 fall outside raw and are dropped here.
            for (int r = 0; r < NROW; r++) begin
              if (key_index(col_q, 2'(r)) < KEY_W'(NKEY))
                raw_d[key_index(col_q, 2'(r))] = ~row_n[r];
            end
          end else begin
            raw_d = raw_q;
          end
          if (tick_q == TICK_W'(SCAN_DIV - 1)) begin
            tick_d = {TICK_W{1'b0}};
            if (col_q == 2'd2) begin
              col_d   = 2'd0;
              frame_d = 1'b1;
            end else begin
              col_d = col_q + 2'd1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = {TICK_W{1'b0}};
        col_d   = 2'd0;
      end
    endcase
  end

  // Column drive follows the next state so col_n lines up with state_q/col_q.
  always_comb begin
    if (state_d == DRIVE) col_n_d = ~(NCOL'(1) << col_d);
    else                  col_n_d = {NCOL{1'b1}};
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= {TICK_W{1'b0}};
      col_q        <= 2'd0;
      raw_q        <= {NKEY{1'b0}};
      col_n_q      <= {NCOL{1'b1}};
      frame_done_q <= 1'b0;
      key_code_q   <= {KEY_W{1'b0}};
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      col_q        <= col_d;
      raw_q        <= raw_d;
      col_n_q      <= col_n_d;
      frame_done_q <= frame_d;
      key_code_q   <= lowest_set(rise_s);
      key_valid_q  <= |rise_s;
    end
  end

  for (genvar k = 0; k < NKEY; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .eval_i (frame_done_q),
      .raw_i  (raw_q[k]),
      .level_o(key_level[k]),
      .press_o(key_press[k]),
      .rise_o (rise_s[k])
    );
  end

  assign col_n      = col_n_q;
  assign frame_done = frame_done_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;

endmodule
